// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle between the producer agents, the arbiter and the shared FIFO.
// master is the arbiter's view; slave is the surrounding environment's view.
`timescale 1ns/1ps
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_WIDTH = 16
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            gnt;
  logic [NUM_REQ-1:0]            err;
  logic                          wr_en;
  logic [FIFO_WIDTH-1:0]         data_in;
  logic                          wr_ack;
  logic                          overflow;
  logic                          full;
  logic                          busy;
  logic [15:0]                   wr_count;

  modport master (
    input  req, req_data, wr_ack, overflow, full,
    output gnt, err, wr_en, data_in, busy, wr_count
  );

  modport slave (
    output req, req_data, wr_ack, overflow, full,
    input  gnt, err, wr_en, data_in, busy, wr_count
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers,
// with per-word retry on rejected writes and grant/error pulses back to the owner.
`timescale 1ns/1ps
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_WIDTH = 16,
  parameter int RETRY_MAX  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  fifo_wr_arbiter_if.master bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int ATT_W = $clog2(RETRY_MAX + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP, WAIT} state_e;

  state_e                state_q;
  logic [IDX_W-1:0]      owner_q;
  logic [IDX_W-1:0]      rr_ptr_q;
  logic [ATT_W-1:0]      attempt_q;
  logic [FIFO_WIDTH-1:0] data_hold_q;
  logic [FIFO_WIDTH-1:0] data_in_q;
  logic [NUM_REQ-1:0]    gnt_q;
  logic [NUM_REQ-1:0]    err_q;
  logic                  wr_en_q;
  logic                  busy_q;
  logic [15:0]           wr_count_q;

  logic [NUM_REQ-1:0]    eligible;
  logic                  pick_vld;
  logic [IDX_W-1:0]      pick_idx;

  // A producer being pulsed this cycle is still holding its old req; mask it out.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    eligible = bus.req & ~gnt_q & ~err_q;
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      int idx;
      idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!pick_vld && eligible[idx]) begin
        pick_vld = 1'b1;
        pick_idx = IDX_W'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= IDX_W'(NUM_REQ - 1);
      attempt_q   <= '0;
      data_hold_q <= '0;
      data_in_q   <= '0;
      gnt_q       <= '0;
      err_q       <= '0;
      wr_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      wr_count_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every flop
      // samples the pre-edge values regardless of statement order.
      gnt_q <= '0;
      err_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (pick_vld && !bus.full) begin
            owner_q     <= pick_idx;
            data_hold_q <= bus.req_data[pick_idx*FIFO_WIDTH +: FIFO_WIDTH];
            data_in_q   <= bus.req_data[pick_idx*FIFO_WIDTH +: FIFO_WIDTH];
            attempt_q   <= '0;
            wr_en_q     <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          wr_en_q <= 1'b0;
          state_q <= RESP;
        end
        RESP: begin
          // wr_ack wins over overflow; silence from the FIFO counts as a failure.
          if (bus.wr_ack) begin
            gnt_q[owner_q] <= 1'b1;
            wr_count_q     <= wr_count_q + 16'd1;
            rr_ptr_q       <= owner_q;
            busy_q         <= 1'b0;
            state_q        <= IDLE;
          end else begin
            attempt_q <= attempt_q + ATT_W'(1);
            if (int'(attempt_q) + 1 == RETRY_MAX) begin
              err_q[owner_q] <= 1'b1;
              rr_ptr_q       <= owner_q;
              busy_q         <= 1'b0;
              state_q        <= IDLE;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!bus.full) begin
            wr_en_q   <= 1'b1;
            data_in_q <= data_hold_q;
            state_q   <= ISSUE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.err      = err_q;
  assign bus.wr_en    = wr_en_q;
  assign bus.data_in  = data_in_q;
  assign bus.busy     = busy_q;
  assign bus.wr_count = wr_count_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus randomized traffic, every cycle
// compared against a transaction-timeline reference model of the arbitration rules.
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int FIFO_WIDTH = 16;
  localparam int RETRY_MAX  = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NUM_REQ(NUM_REQ), .FIFO_WIDTH(FIFO_WIDTH)) bus ();

  fifo_wr_arbiter #(
    .NUM_REQ(NUM_REQ), .FIFO_WIDTH(FIFO_WIDTH), .RETRY_MAX(RETRY_MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  // Producers and FIFO-response environment
  logic [NUM_REQ-1:0] pend;
  logic [NUM_REQ-1:0] prod_active;
  logic [NUM_REQ-1:0] served;
  logic [15:0]        word [NUM_REQ];
  int  req_pct, ack_pct, full_pct, ovf_left;
  bit  full_rand, full_fixed;
  bit  rsp_v, rsp_ack, rsp_ovf;

  // Logs of observed DUT events
  typedef struct {int idx; bit is_err; int cyc;} ev_t;
  ev_t         ev_q[$];
  int          wr_cyc_q[$];
  logic [15:0] wr_dat_q[$];

  // Reference model: expected outputs for the coming cycle
  logic              e_wr_en, e_busy;
  logic [15:0]       e_data, e_wr_count;
  logic [NUM_REQ-1:0] e_gnt, e_err;
  int m_rr, m_owner, m_fails, m_issued;
  bit m_txn, m_retry;
  logic [15:0] m_word;

  task automatic model_reset();
    e_wr_en = 1'b0; e_busy = 1'b0; e_data = '0; e_wr_count = '0;
    e_gnt = '0; e_err = '0;
    m_rr = NUM_REQ - 1; m_owner = 0; m_fails = 0; m_issued = -10;
    m_txn = 1'b0; m_retry = 1'b0; m_word = '0;
  endtask

  // Timeline rules: pick -> write next cycle -> response one cycle later ->
  // pulse the cycle after; a failed word waits for full=0 before its next write.
  task automatic model_step();
    logic [NUM_REQ-1:0] elig, n_gnt, n_err;
    logic n_wr_en;
    bit found;
    n_wr_en = 1'b0; n_gnt = '0; n_err = '0; found = 1'b0;
    if (!m_txn) begin
      elig = bus.req & ~e_gnt & ~e_err;
      if (elig != '0 && !bus.full) begin
        for (int k = 1; k <= NUM_REQ; k++) begin
          if (!found && elig[(m_rr + k) % NUM_REQ]) begin
            found = 1'b1;
            m_owner = (m_rr + k) % NUM_REQ;
          end
        end
        m_word   = bus.req_data[m_owner*FIFO_WIDTH +: FIFO_WIDTH];
        m_fails  = 0;
        m_txn    = 1'b1;
        n_wr_en  = 1'b1;
        e_data   = m_word;
        m_issued = cyc + 1;
      end
    end else if (cyc == m_issued + 1) begin
      if (bus.wr_ack) begin
        n_gnt[m_owner] = 1'b1;
        e_wr_count = e_wr_count + 16'd1;
        m_rr = m_owner;
        m_txn = 1'b0;
      end else begin
        m_fails++;
        if (m_fails == RETRY_MAX) begin
          n_err[m_owner] = 1'b1;
          m_rr = m_owner;
          m_txn = 1'b0;
        end else begin
          m_retry = 1'b1;
        end
      end
    end else if (m_retry && !bus.full) begin
      n_wr_en  = 1'b1;
      e_data   = m_word;
      m_issued = cyc + 1;
      m_retry  = 1'b0;
    end
    e_wr_en = n_wr_en;
    e_gnt   = n_gnt;
    e_err   = n_err;
    e_busy  = m_txn;
  endtask

  // Monitor: compares at the falling edge, logs events, decides FIFO responses.
  initial begin
    int r;
    model_reset();
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        model_reset();
        rsp_v  = 1'b0;
        served = '0;
      end else begin
        check("wr_en", 32'(bus.wr_en), 32'(e_wr_en));
        if (e_wr_en) check("data_in", 32'(bus.data_in), 32'(e_data));
        check("gnt", 32'(bus.gnt), 32'(e_gnt));
        check("err", 32'(bus.err), 32'(e_err));
        check("busy", 32'(bus.busy), 32'(e_busy));
        check("wr_count", 32'(bus.wr_count), 32'(e_wr_count));
        served = bus.gnt | bus.err;
        for (int i = 0; i < NUM_REQ; i++) begin
          if (bus.gnt[i]) ev_q.push_back('{idx: i, is_err: 1'b0, cyc: cyc});
          if (bus.err[i]) ev_q.push_back('{idx: i, is_err: 1'b1, cyc: cyc});
        end
        rsp_v = bus.wr_en;
        if (bus.wr_en) begin
          wr_cyc_q.push_back(cyc);
          wr_dat_q.push_back(bus.data_in);
          if (ovf_left > 0) begin
            rsp_ack = 1'b0; rsp_ovf = 1'b1; ovf_left--;
          end else begin
            r = int'($urandom_range(99));
            if (r < ack_pct) begin
              rsp_ack = 1'b1; rsp_ovf = (r % 7 == 0);
            end else begin
              rsp_ack = 1'b0; rsp_ovf = r[0];
            end
          end
        end
        model_step();
      end
    end
  end

  // Driver: all inputs change 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (served[i]) pend[i] = 1'b0;
      if (!pend[i] && prod_active[i] && $urandom_range(99) < req_pct) begin
        pend[i] = 1'b1;
        word[i] = 16'($urandom);
      end
      bus.req_data[i*FIFO_WIDTH +: FIFO_WIDTH] = word[i];
    end
    bus.req      = pend;
    bus.full     = full_rand ? ($urandom_range(99) < full_pct) : full_fixed;
    bus.wr_ack   = rsp_v & rsp_ack;
    bus.overflow = rsp_v & rsp_ovf;
  endtask

  task automatic clear_logs();
    ev_q.delete();
    wr_cyc_q.delete();
    wr_dat_q.delete();
  endtask

  task automatic apply_reset();
    prod_active = '0;
    pend = '0;
    tick();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    clear_logs();
  endtask

  task automatic wait_events(input string tag, input int n, input int budget);
    int b;
    b = 0;
    while (ev_q.size() < n && b < budget) begin
      tick();
      b++;
    end
    check(tag, ev_q.size(), n);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int pick;
    logic [15:0] w1;
    bus.req = '0; bus.req_data = '0; bus.wr_ack = 1'b0; bus.overflow = 1'b0; bus.full = 1'b0;
    pend = '0; prod_active = '0; served = '0;
    for (int i = 0; i < NUM_REQ; i++) word[i] = '0;
    req_pct = 100; ack_pct = 100; full_pct = 0; ovf_left = 0;
    full_rand = 1'b0; full_fixed = 1'b0;
    rsp_v = 1'b0; rsp_ack = 1'b0; rsp_ovf = 1'b0;

    // Single uncontended write
    apply_reset();
    pend[0] = 1'b1; word[0] = 16'hA5A5;
    tick();
    pick = cyc + 1;
    wait_events("single_events", 1, 20);
    if (ev_q.size() > 0) begin
      check("single_gnt_idx", ev_q[0].idx, 0);
      check("single_gnt_lat", ev_q[0].cyc - pick, 3);
    end
    if (wr_cyc_q.size() > 0) begin
      check("single_wr_lat", wr_cyc_q[0] - pick, 1);
      check("single_wr_data", 32'(wr_dat_q[0]), 32'hA5A5);
    end
    check("single_wr_count", 32'(bus.wr_count), 1);

    // Reset in the middle of ISSUE abandons the write
    repeat (3) tick();
    clear_logs();
    pend[0] = 1'b1; word[0] = 16'h1234;
    tick();
    tick();
    check("pre_rst_wr_en", 32'(bus.wr_en), 1);
    rst_n = 1'b0;
    #1;
    check("rst_wr_en", 32'(bus.wr_en), 0);
    check("rst_gnt", 32'(bus.gnt), 0);
    check("rst_err", 32'(bus.err), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_wr_count", 32'(bus.wr_count), 0);
    tick();
    tick();
    rst_n = 1'b1;
    clear_logs();
    pick = cyc + 1;
    wait_events("post_rst_events", 1, 20);
    if (ev_q.size() > 0) begin
      check("post_rst_idx", ev_q[0].idx, 0);
      check("post_rst_lat", ev_q[0].cyc - pick, 3);
    end

    // Round-robin with all producers continuously requesting
    apply_reset();
    prod_active = '1; req_pct = 100;
    wait_events("rr_events", 5, 60);
    check("rr_wr_count", 32'(bus.wr_count), 5);
    prod_active = '0;
    for (int k = 0; k < ev_q.size() && k < 5; k++) begin
      check($sformatf("rr_order%0d", k), ev_q[k].idx, k % NUM_REQ);
      if (k > 0) check($sformatf("rr_gap%0d", k), ev_q[k].cyc - ev_q[k-1].cyc, 3);
    end
    repeat (20) tick();

    // Full gating
    apply_reset();
    full_fixed = 1'b1;
    pend[2] = 1'b1; word[2] = 16'h0F0F;
    repeat (10) tick();
    check("full_no_wr_en", wr_cyc_q.size(), 0);
    full_fixed = 1'b0;
    tick();
    pick = cyc + 1;
    wait_events("full_events", 1, 20);
    if (ev_q.size() > 0) begin
      check("full_gnt_idx", ev_q[0].idx, 2);
      check("full_gnt_lat", ev_q[0].cyc - pick, 3);
    end
    if (wr_cyc_q.size() > 0) check("full_wr_lat", wr_cyc_q[0] - pick, 1);

    // Three overflows drop producer 1; producer 2 is served next
    apply_reset();
    w1 = 16'h3C5A;
    ovf_left = RETRY_MAX;
    pend[1] = 1'b1; word[1] = w1;
    pend[2] = 1'b1; word[2] = ~w1;
    tick();
    wait_events("drop_events", 2, 60);
    if (ev_q.size() >= 2) begin
      check("drop_idx", ev_q[0].idx, 1);
      check("drop_is_err", 32'(ev_q[0].is_err), 1);
      check("drop_next_idx", ev_q[1].idx, 2);
      check("drop_next_gnt", 32'(ev_q[1].is_err), 0);
    end
    check("drop_wr_pulses", wr_dat_q.size(), RETRY_MAX + 1);
    for (int k = 0; k < wr_dat_q.size() && k < RETRY_MAX; k++)
      check($sformatf("drop_retry_data%0d", k), 32'(wr_dat_q[k]), 32'(w1));
    check("drop_wr_count", 32'(bus.wr_count), 1);

    // One overflow then ack: grant 3 cycles later than uncontended
    repeat (5) tick();
    clear_logs();
    ovf_left = 1;
    pend[1] = 1'b1; word[1] = 16'h7E81;
    tick();
    pick = cyc + 1;
    wait_events("retry_events", 1, 30);
    if (ev_q.size() > 0) begin
      check("retry_idx", ev_q[0].idx, 1);
      check("retry_is_err", 32'(ev_q[0].is_err), 0);
      check("retry_lat", ev_q[0].cyc - pick, 6);
    end

    // Counter wrap from a preloaded 0xFFFF
    repeat (5) tick();
    clear_logs();
    force dut.wr_count_q = 16'hFFFF;
    e_wr_count = 16'hFFFF;
    #1;
    release dut.wr_count_q;
    pend[3] = 1'b1; word[3] = 16'hBEEF;
    tick();
    wait_events("wrap_events", 1, 20);
    check("wrap_wr_count", 32'(bus.wr_count), 0);

    // Randomized traffic with random backpressure and FIFO responses
    apply_reset();
    prod_active = '1; req_pct = 30; ack_pct = 70;
    full_rand = 1'b1; full_pct = 15;
    repeat (3000) tick();
    prod_active = '0; ack_pct = 100; full_rand = 1'b0; full_fixed = 1'b0;
    repeat (60) tick();
    check("rand_drained_busy", 32'(bus.busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
